uart_cap_sequencer: RTL and testbench
=====================================

Name: uart_cap_sequencer

Overview:
Sequencer between the RX byte FIFO (read side) and the TX byte FIFO (write side) of the UART capitalizer. It pops one byte at a time, optionally upper-cases ASCII a–z, optionally expands CR into CR+LF, and pushes the result downstream under TX-full back-pressure. It owns all FIFO read/write enables in the datapath and keeps a processed-byte counter plus a sticky protocol-error flag.

Parameters:
DATA_WIDTH, 8, byte width; only 8 is supported.
CNT_WIDTH, 16, width of processed-byte counter.
CR_CHAR, 8'h0D, character that triggers LF insertion.
LF_CHAR, 8'h0A, character inserted after CR_CHAR.

Ports:
i_clk  input  1  clock, all logic on rising edge
i_rst_n  input  1  asynchronous active-low reset
i_en  input  1  enable; sampled only when starting a new byte
i_cap_en  input  1  1 = upper-case a–z, 0 = pass-through
i_crlf_en  input  1  1 = emit LF_CHAR after every CR_CHAR
o_rx_rd_en  output  1  RX FIFO read strobe
i_rx_rd_data  input  8  RX FIFO read data, valid with i_rx_rd_valid
i_rx_rd_valid  input  1  RX FIFO read-valid, one cycle after the accepted strobe
i_rx_empty  input  1  RX FIFO empty
o_tx_wr_en  output  1  TX FIFO write strobe
o_tx_wr_data  output  8  TX FIFO write data
i_tx_full  input  1  TX FIFO full
o_busy  output  1  high whenever state != IDLE
o_byte_count  output  CNT_WIDTH  bytes popped from RX since reset
o_err  output  1  sticky: expected read-valid did not arrive

Behaviour:
- Reset (i_rst_n low, async): state=IDLE; o_rx_rd_en=0, o_tx_wr_en=0, o_tx_wr_data=0, o_busy=0, o_byte_count=0, o_err=0; held byte register=0. Any in-flight byte is discarded.
- States: IDLE, READ, WAIT, WRITE, LF.
- IDLE: if i_en && !i_rx_empty, go to READ; otherwise stay.
- READ: o_rx_rd_en=1 for exactly this cycle; go to WAIT unconditionally.
- WAIT: if i_rx_rd_valid, latch xform(i_rx_rd_data) into the byte register, o_byte_count+=1 (wraps at 2^CNT_WIDTH), go to WRITE. If not valid, set o_err=1 and return to IDLE; the counter does not change.
- xform: if i_cap_en and the byte is in 0x61..0x7A, subtract 0x20; otherwise pass unchanged. i_cap_en and i_crlf_en are sampled in WAIT.
- WRITE: o_tx_wr_data=byte register; o_tx_wr_en = !i_tx_full (same cycle, decoded from state and full); stay in WRITE while full.
  - On an accepted write, if the byte == CR_CHAR and i_crlf_en (latched in WAIT), go to LF.
  - Otherwise, if i_en && !i_rx_empty, go directly to READ (back-to-back).
  - Otherwise go to IDLE.
- LF: o_tx_wr_data=LF_CHAR; o_tx_wr_en = !i_tx_full; on acceptance, use the same next-state rule as WRITE (READ or IDLE).
- Throughput: 3 cycles per byte when streaming with no back-pressure; 4 cycles from IDLE; +1 per inserted LF.
- Strobe rules: o_rx_rd_en and o_tx_wr_en are never high together. A write is never issued while i_tx_full=1. A read is never issued while i_rx_empty=1.
- Deasserting i_en mid-byte has no effect: the current byte, including any pending LF, completes, then the block returns to IDLE.
- The byte register holds its value in IDLE; o_tx_wr_data is don't-care when o_tx_wr_en=0, but stays stable for the whole duration of a WRITE stall.
- o_err is cleared only by reset.

Decomposition:
- Shared package uart_cap_pkg:
  - state enum (IDLE, READ, WAIT, WRITE, LF);
  - ASCII constants: LOWER_A=8'h61, LOWER_Z=8'h7A, CASE_DELTA=8'h20, CR, LF.
- One combinational sub-module, ascii_upper (8-bit in, cap_en, 8-bit out), reused by any later case-mapping block.
- The FSM, counter and error flag stay in uart_cap_sequencer.

Test Plan:
- Reset, then push "aZ{" (0x61,0x5A,0x7B) into the RX model with i_cap_en=1 → TX receives 0x41,0x5A,0x7B; o_byte_count=3; write strobes 3 cycles apart after the first; o_err=0.
- i_cap_en=0, push 0x61,0x7A → TX receives 0x61,0x7A unchanged.
- i_crlf_en=1, push 0x0D,0x62 → TX receives 0x0D,0x0A,0x42; o_byte_count=2.
- Hold i_tx_full=1 for 10 cycles during WRITE of 0x63 → no o_tx_wr_en and o_tx_wr_data stable at 0x43; write occurs in the cycle full drops; o_busy=1 throughout.
- Suppress i_rx_rd_valid after a read strobe → o_err=1, return to IDLE, count unchanged; next byte 0x64 processed normally to 0x44, o_err stays 1.
- Drop i_rst_n mid-WRITE → all outputs 0 immediately; after release with i_en=0 and RX non-empty → no read strobe issued.

Source files
------------

// File: rtl/uart_cap_pkg.sv
// Shared types and ASCII constants for the UART capitalizer datapath.
// The state enum and case-mapping helper are reused by the sequencer and ascii_upper.
package uart_cap_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_READ  = 3'd1,
        ST_WAIT  = 3'd2,
        ST_WRITE = 3'd3,
        ST_LF    = 3'd4
    } state_e;

    localparam logic [7:0] LOWER_A    = 8'h61;
    localparam logic [7:0] LOWER_Z    = 8'h7A;
    localparam logic [7:0] CASE_DELTA = 8'h20;
    localparam logic [7:0] CR         = 8'h0D;
    localparam logic [7:0] LF         = 8'h0A;

    function automatic logic is_lower(input logic [7:0] b);
        return (b >= LOWER_A) && (b <= LOWER_Z);
    endfunction

endpackage

// File: rtl/ascii_upper.sv
// Combinational ASCII upper-caser: maps a-z to A-Z when enabled, passes
// every other code through unchanged.
module ascii_upper
    import uart_cap_pkg::*;
(
    input  logic [7:0] i_data,
    input  logic       i_cap_en,
    output logic [7:0] o_data
);

    always_comb begin
        o_data = i_data;
        if (i_cap_en && is_lower(i_data)) begin
            o_data = i_data - CASE_DELTA;
        end
    end

endmodule

// File: rtl/uart_cap_sequencer.sv
// Moves bytes from the RX FIFO to the TX FIFO one at a time, upper-casing and
// expanding CR into CR+LF on the way, with a popped-byte counter and sticky error.
module uart_cap_sequencer
    import uart_cap_pkg::*;
#(
    parameter int                    DATA_WIDTH = 8,
    parameter int                    CNT_WIDTH  = 16,
    parameter logic [DATA_WIDTH-1:0] CR_CHAR    = CR,
    parameter logic [DATA_WIDTH-1:0] LF_CHAR    = LF
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_en,
    input  logic                  i_cap_en,
    input  logic                  i_crlf_en,
    output logic                  o_rx_rd_en,
    input  logic [DATA_WIDTH-1:0] i_rx_rd_data,
    input  logic                  i_rx_rd_valid,
    input  logic                  i_rx_empty,
    output logic                  o_tx_wr_en,
    output logic [DATA_WIDTH-1:0] o_tx_wr_data,
    input  logic                  i_tx_full,
    output logic                  o_busy,
    output logic [CNT_WIDTH-1:0]  o_byte_count,
    output logic                  o_err
);

    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] byte_q, byte_d;
    logic                  crlf_q, crlf_d;
    logic [CNT_WIDTH-1:0]  count_q, count_d;
    logic                  err_q, err_d;

    logic [DATA_WIDTH-1:0] xform_byte;
    logic                  start_ok;

    ascii_upper u_upper (
        .i_data   (i_rx_rd_data),
        .i_cap_en (i_cap_en),
        .o_data   (xform_byte)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
            byte_q  <= '0;
            crlf_q  <= 1'b0;
            count_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            byte_q  <= byte_d;
            crlf_q  <= crlf_d;
            count_q <= count_d;
            err_q   <= err_d;
        end
    end

    // A new byte may only start when enabled and RX has data; used from IDLE
    // and as the back-to-back exit from WRITE/LF.
    assign start_ok = i_en && !i_rx_empty;

    always_comb begin
        state_d = state_q;
        byte_d  = byte_q;
        crlf_d  = crlf_q;
        count_d = count_q;
        err_d   = err_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start_ok) state_d = ST_READ;
            end
            ST_READ: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (i_rx_rd_valid) begin
                    byte_d  = xform_byte;
                    crlf_d  = i_crlf_en;
                    count_d = count_q + CNT_WIDTH'(1);
                    state_d = ST_WRITE;
                end else begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            ST_WRITE: begin
                if (!i_tx_full) begin
                    if (crlf_q && (byte_q == CR_CHAR)) state_d = ST_LF;
                    else if (start_ok)                 state_d = ST_READ;
                    else                               state_d = ST_IDLE;
                end
            end
            ST_LF: begin
                if (!i_tx_full) begin
                    state_d = start_ok ? ST_READ : ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Strobes are decoded from state so read and write can never overlap.
    always_comb begin
        o_rx_rd_en   = (state_q == ST_READ);
        o_tx_wr_en   = ((state_q == ST_WRITE) || (state_q == ST_LF)) && !i_tx_full;
        o_tx_wr_data = (state_q == ST_LF) ? LF_CHAR : byte_q;
        o_busy       = (state_q != ST_IDLE);
    end

    assign o_byte_count = count_q;
    assign o_err        = err_q;

endmodule

// File: tb/tb_uart_cap_sequencer.sv
// Randomized scoreboard bench: an RX FIFO model feeds the sequencer, a reference
// model predicts the TX byte stream, and a monitor compares every TX write.
module tb_uart_cap_sequencer;

    logic        clk;
    logic        rst_n;
    logic        i_en, i_cap_en, i_crlf_en;
    logic        o_rx_rd_en;
    logic [7:0]  i_rx_rd_data;
    logic        i_rx_rd_valid;
    logic        i_rx_empty;
    logic        o_tx_wr_en;
    logic [7:0]  o_tx_wr_data;
    logic        i_tx_full;
    logic        o_busy;
    logic [15:0] o_byte_count;
    logic        o_err;

    uart_cap_sequencer dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_en          (i_en),
        .i_cap_en      (i_cap_en),
        .i_crlf_en     (i_crlf_en),
        .o_rx_rd_en    (o_rx_rd_en),
        .i_rx_rd_data  (i_rx_rd_data),
        .i_rx_rd_valid (i_rx_rd_valid),
        .i_rx_empty    (i_rx_empty),
        .o_tx_wr_en    (o_tx_wr_en),
        .o_tx_wr_data  (o_tx_wr_data),
        .i_tx_full     (i_tx_full),
        .o_busy        (o_busy),
        .o_byte_count  (o_byte_count),
        .o_err         (o_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          rd_strobes = 0;
    logic [7:0]  rxq[$];
    logic [7:0]  sbq[$];
    int          wr_cyc[$];
    logic [15:0] count_exp = 0;
    logic        err_exp = 0;
    bit          suppress_next = 0;
    bit          rd_seen = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference transform: what the TX side must receive for one popped RX byte.
    task automatic model_push(input logic [7:0] b);
        logic [7:0] up;
        up = b;
        if (i_cap_en && b >= 8'h61 && b <= 8'h7A) up = b - 8'h20;
        sbq.push_back(up);
        if (i_crlf_en && up == 8'h0D) sbq.push_back(8'h0A);
    endtask

    always @(posedge clk) cyc++;

    // Monitor first, then the RX FIFO model (read data one cycle after strobe).
    always @(negedge clk) begin
        logic [7:0] b;
        logic [7:0] e;
        if (!rst_n) begin
            rd_seen       = 0;
            i_rx_rd_valid = 0;
            sbq.delete();
            count_exp     = 0;
            err_exp       = 0;
        end else begin
            if (o_rx_rd_en) begin
                rd_strobes++;
                chk("rd_when_empty", {31'd0, i_rx_empty}, 0);
            end
            if (o_tx_wr_en) begin
                chk("wr_while_full", {31'd0, i_tx_full}, 0);
                chk("rd_wr_overlap", {31'd0, o_rx_rd_en}, 0);
                if (sbq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL tx_unexpected: got 0x%0h expected no write", o_tx_wr_data);
                end else begin
                    e = sbq.pop_front();
                    chk("tx_data", {24'd0, o_tx_wr_data}, {24'd0, e});
                    $display("tx write 0x%02h at cycle %0d", o_tx_wr_data, cyc);
                end
                wr_cyc.push_back(cyc);
            end
            i_rx_rd_valid = 0;
            if (rd_seen) begin
                b = (rxq.size() > 0) ? rxq.pop_front() : 8'h00;
                if (suppress_next) begin
                    suppress_next = 0;
                    err_exp       = 1;
                end else begin
                    i_rx_rd_valid = 1;
                    i_rx_rd_data  = b;
                    model_push(b);
                    count_exp     = count_exp + 16'd1;
                end
            end
            rd_seen = o_rx_rd_en;
        end
        i_rx_empty = (rxq.size() == 0);
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drain(input string nm, input bit rand_full);
        int k;
        for (k = 0; k < 400; k++) begin
            if (rxq.size() == 0 && sbq.size() == 0 && !o_busy && !rd_seen) break;
            if (rand_full) i_tx_full = ($urandom % 4 == 0);
            tick(1);
        end
        i_tx_full = 0;
        tick(1);
        if (k >= 400) chk({nm, "_timeout"}, 1, 0);
    endtask

    logic [15:0] cnt_before;
    int          st_cyc;
    int          rd_before;

    initial begin
        rst_n = 0; i_en = 0; i_cap_en = 0; i_crlf_en = 0;
        i_rx_rd_data = 0; i_rx_rd_valid = 0; i_rx_empty = 1; i_tx_full = 0;
        #1;
        chk("rst_rd_en", {31'd0, o_rx_rd_en}, 0);
        chk("rst_wr_en", {31'd0, o_tx_wr_en}, 0);
        chk("rst_wr_data", {24'd0, o_tx_wr_data}, 0);
        chk("rst_busy", {31'd0, o_busy}, 0);
        chk("rst_count", {16'd0, o_byte_count}, 0);
        chk("rst_err", {31'd0, o_err}, 0);
        tick(3);
        rst_n = 1;
        tick(2);

        // "aZ{" with capitalization, streamed back to back
        i_cap_en = 1;
        rxq.push_back(8'h61); rxq.push_back(8'h5A); rxq.push_back(8'h7B);
        tick(2);
        wr_cyc.delete();
        st_cyc = cyc;
        i_en = 1;
        drain("t1", 0);
        chk("t1_count", {16'd0, o_byte_count}, 3);
        chk("t1_err", {31'd0, o_err}, 0);
        if (wr_cyc.size() >= 3) begin
            chk("t1_first_latency", wr_cyc[0] - st_cyc, 3);
            chk("t1_gap0", wr_cyc[1] - wr_cyc[0], 3);
            chk("t1_gap1", wr_cyc[2] - wr_cyc[1], 3);
        end else begin
            chk("t1_write_count", wr_cyc.size(), 3);
        end

        // pass-through
        i_cap_en = 0;
        rxq.push_back(8'h61); rxq.push_back(8'h7A);
        drain("t2", 0);
        chk("t2_count", {16'd0, o_byte_count}, 5);

        // CR expansion
        i_cap_en = 1; i_crlf_en = 1;
        rxq.push_back(8'h0D); rxq.push_back(8'h62);
        drain("t3", 0);
        chk("t3_count", {16'd0, o_byte_count}, 7);

        // TX back-pressure stall
        i_crlf_en = 0;
        i_tx_full = 1;
        rxq.push_back(8'h63);
        tick(5);
        for (int i = 0; i < 10; i++) begin
            chk("stall_wr_en", {31'd0, o_tx_wr_en}, 0);
            chk("stall_data", {24'd0, o_tx_wr_data}, 8'h43);
            chk("stall_busy", {31'd0, o_busy}, 1);
            tick(1);
        end
        i_tx_full = 0;
        @(negedge clk);
        chk("stall_release_wr", {31'd0, o_tx_wr_en}, 1);
        tick(1);
        drain("t4", 0);

        // missing read-valid
        cnt_before = o_byte_count;
        suppress_next = 1;
        rxq.push_back(8'h70);
        drain("t5a", 0);
        chk("t5_err", {31'd0, o_err}, 1);
        chk("t5_busy", {31'd0, o_busy}, 0);
        chk("t5_count_hold", {16'd0, o_byte_count}, {16'd0, cnt_before});
        rxq.push_back(8'h64);
        drain("t5b", 0);
        chk("t5_err_sticky", {31'd0, o_err}, 1);
        chk("t5_count", {16'd0, o_byte_count}, {16'd0, cnt_before + 16'd1});

        // async reset during a stalled WRITE
        i_tx_full = 1;
        rxq.push_back(8'h65);
        tick(6);
        chk("t6_busy_pre", {31'd0, o_busy}, 1);
        rst_n = 0;
        #1;
        chk("t6_rd_en", {31'd0, o_rx_rd_en}, 0);
        chk("t6_wr_en", {31'd0, o_tx_wr_en}, 0);
        chk("t6_wr_data", {24'd0, o_tx_wr_data}, 0);
        chk("t6_busy", {31'd0, o_busy}, 0);
        chk("t6_count", {16'd0, o_byte_count}, 0);
        chk("t6_err", {31'd0, o_err}, 0);
        i_tx_full = 0;
        i_en = 0;
        rxq.push_back(8'h66);
        tick(3);
        rst_n = 1;
        rd_before = rd_strobes;
        tick(10);
        chk("t6_no_read", rd_strobes, rd_before);
        chk("t6_idle", {31'd0, o_busy}, 0);

        // randomized batches with random back-pressure
        i_en = 1;
        drain("t7_pre", 0);
        for (int bt = 0; bt < 8; bt++) begin
            i_cap_en  = $urandom % 2;
            i_crlf_en = $urandom % 2;
            for (int j = 0; j < 4 + $urandom % 5; j++) begin
                case ($urandom % 4)
                    0: rxq.push_back(8'h0D);
                    1: rxq.push_back(8'(8'h61 + $urandom % 26));
                    default: rxq.push_back(8'($urandom % 256));
                endcase
            end
            drain("rand", 1);
            chk("rand_count", {16'd0, o_byte_count}, {16'd0, count_exp});
            chk("rand_err", {31'd0, o_err}, {31'd0, err_exp});
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
